// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return address stack speculation controller with checkpoint repair
// Optional RAS_CTRL_STATS_EN builds the overflow/recover counters; otherwise they read 0.
module ras_ctrl #(
  parameter int STACK_DEPTH = 8,
  parameter int CKPT_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          f_valid_i,
  output logic                          f_ready_o,
  input  logic                          f_call_i,
  input  logic                          f_ret_i,
  input  logic [31:2]                   f_target_i,
  output logic [$clog2(CKPT_DEPTH)-1:0] f_ckpt_id_o,
  output logic [31:2]                   pred_target_o,
  output logic                          pred_valid_o,
  input  logic                          commit_i,
  input  logic                          redirect_i,
  input  logic [$clog2(CKPT_DEPTH)-1:0] redirect_id_i,
  input  logic                          redirect_call_i,
  input  logic                          redirect_ret_i,
  input  logic [31:2]                   redirect_target_i,
  output logic [15:0]                   overflow_cnt_o,
  output logic [15:0]                   recover_cnt_o
);
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int ID_W  = $clog2(CKPT_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {NORMAL, RESTORE, REPLAY} state_t;
  state_t state, state_nx;

  logic [31:2]      stack [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_nx;
  logic [CNT_W-1:0] count, count_nx;

  logic [SP_W-1:0]  ck_sp  [CKPT_DEPTH];
  logic [31:2]      ck_top [CKPT_DEPTH];
  logic [CNT_W-1:0] ck_cnt [CKPT_DEPTH];
  logic [ID_W:0]    head, tail, head_nx, rid_ptr;
  logic [ID_W-1:0]  rid_off;

  logic             rp_call, rp_ret;
  logic [31:2]      rp_target;

  logic             ckpt_empty, ckpt_full, accept, replay, commit_go;
  logic             op_call, op_ret, op_live, push, pop, swap;
  logic [31:2]      op_target;
  logic             st_we;
  logic [SP_W-1:0]  st_addr;
  logic [31:2]      st_data;

  // The extra MSB on head/tail separates a full queue from an empty one.
  assign ckpt_empty = (head == tail);
  assign ckpt_full  = (head[ID_W] != tail[ID_W]) && (head[ID_W-1:0] == tail[ID_W-1:0]);
  assign f_ready_o  = rst_n && (state == NORMAL) && !ckpt_full && !redirect_i;
  assign accept     = f_valid_i && f_ready_o;
  assign replay     = (state == RESTORE) && !redirect_i;
  assign commit_go  = commit_i && !ckpt_empty;
  assign head_nx    = head + (ID_W+1)'(commit_go);
  assign rid_off    = redirect_id_i - head[ID_W-1:0];
  assign rid_ptr    = head + {1'b0, rid_off};

  // Fetch accepts and the replayed corrected op share one set of stack-update rules.
  assign op_call   = accept ? f_call_i   : rp_call;
  assign op_ret    = accept ? f_ret_i    : rp_ret;
  assign op_target = accept ? f_target_i : rp_target;
  assign op_live   = accept || replay;
  assign push      = op_live && op_call && !op_ret;
  assign pop       = op_live && op_ret && !op_call;
  assign swap      = op_live && op_call && op_ret;

  assign pred_target_o = stack[sp];
  assign pred_valid_o  = (count != '0);
  assign f_ckpt_id_o   = tail[ID_W-1:0];

  always_comb begin
    state_nx = state;
    sp_nx    = sp;
    count_nx = count;
    st_we    = 1'b0;
    st_addr  = sp;
    st_data  = op_target;
    case (state)
      NORMAL:  state_nx = NORMAL;
      RESTORE: state_nx = REPLAY;
      REPLAY:  state_nx = NORMAL;
      default: state_nx = NORMAL;
    endcase
    if (redirect_i) begin
      state_nx = RESTORE;
      sp_nx    = ck_sp[redirect_id_i];
      count_nx = ck_cnt[redirect_id_i];
      st_we    = 1'b1;
      st_addr  = ck_sp[redirect_id_i];
      st_data  = ck_top[redirect_id_i];
    end else if (push) begin
      sp_nx   = sp + 1'b1;
      st_we   = 1'b1;
      st_addr = sp + 1'b1;
      if (count != CNT_MAX) count_nx = count + 1'b1;
    end else if (pop) begin
      sp_nx = sp - 1'b1;
      if (count != '0) count_nx = count - 1'b1;
    end else if (swap) begin
      st_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= NORMAL;
      sp        <= '0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      rp_call   <= 1'b0;
      rp_ret    <= 1'b0;
      rp_target <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      state <= state_nx;
      sp    <= sp_nx;
      count <= count_nx;
      head  <= head_nx;
      if (st_we) stack[st_addr] <= st_data;
      if (redirect_i) begin
        tail      <= rid_ptr + 1'b1;
        rp_call   <= redirect_call_i;
        rp_ret    <= redirect_ret_i;
        rp_target <= redirect_target_i;
      end else if (accept) begin
        tail <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      ck_sp[tail[ID_W-1:0]]  <= sp;
      ck_top[tail[ID_W-1:0]] <= stack[sp];
      ck_cnt[tail[ID_W-1:0]] <= count;
    end
  end

  // Redirect must name a live checkpoint once this cycle's commit has been applied.
  always_ff @(posedge clk) begin
    if (rst_n && redirect_i)
      assert ({1'b0, redirect_id_i - head_nx[ID_W-1:0]} < (tail - head_nx));
  end

`ifdef RAS_CTRL_STATS_EN
  logic [15:0] ovf_cnt, rec_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      rec_cnt <= '0;
    end else begin
      if (push && !redirect_i && count == CNT_MAX && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      if (redirect_i && rec_cnt != 16'hFFFF) rec_cnt <= rec_cnt + 1'b1;
    end
  end
  assign overflow_cnt_o = ovf_cnt;
  assign recover_cnt_o  = rec_cnt;
`else
  assign overflow_cnt_o = '0;
  assign recover_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - directed and randomized bench for ras_ctrl against a queue-based stack model
module tb_ras_ctrl;
  logic        clk, rst_n;
  logic        f_valid_i, f_ready_o, f_call_i, f_ret_i;
  logic [31:2] f_target_i, pred_target_o, redirect_target_i;
  logic [1:0]  f_ckpt_id_o, redirect_id_i;
  logic        pred_valid_o, commit_i, redirect_i, redirect_call_i, redirect_ret_i;
  logic [15:0] overflow_cnt_o, recover_cnt_o;

  ras_ctrl #(.STACK_DEPTH(8), .CKPT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid_i(f_valid_i), .f_ready_o(f_ready_o),
    .f_call_i(f_call_i), .f_ret_i(f_ret_i), .f_target_i(f_target_i),
    .f_ckpt_id_o(f_ckpt_id_o), .pred_target_o(pred_target_o), .pred_valid_o(pred_valid_o),
    .commit_i(commit_i), .redirect_i(redirect_i), .redirect_id_i(redirect_id_i),
    .redirect_call_i(redirect_call_i), .redirect_ret_i(redirect_ret_i),
    .redirect_target_i(redirect_target_i), .overflow_cnt_o(overflow_cnt_o),
    .recover_cnt_o(recover_cnt_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct { int id; int sp; logic [31:2] top; int cnt; } ck_t;
  logic [31:2] m_stack [8];
  int m_sp, m_cnt, m_head, m_tail, m_stall, m_ovf, m_rec;
  ck_t m_q[$];
  logic p_call, p_ret;
  logic [31:2] p_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_stack[i] = '0;
    m_sp = 0; m_cnt = 0; m_head = 0; m_tail = 0; m_stall = 0; m_ovf = 0; m_rec = 0;
    m_q.delete();
    p_call = 0; p_ret = 0; p_tgt = '0;
  endtask

  task automatic apply_op(input logic c, input logic r, input logic [31:2] t);
    if (c && !r) begin
      if (m_cnt == 8) m_ovf++;
      m_sp = (m_sp + 1) % 8;
      m_stack[m_sp] = t;
      if (m_cnt < 8) m_cnt++;
    end else if (r && !c) begin
      m_sp = (m_sp + 7) % 8;
      if (m_cnt > 0) m_cnt--;
    end else if (c && r) begin
      m_stack[m_sp] = t;
    end
  endtask

  task automatic check_stats();
`ifdef RAS_CTRL_STATS_EN
    chk("overflow_cnt", 32'(overflow_cnt_o), 32'(m_ovf));
    chk("recover_cnt", 32'(recover_cnt_o), 32'(m_rec));
`else
    chk("overflow_cnt", 32'(overflow_cnt_o), 32'd0);
    chk("recover_cnt", 32'(recover_cnt_o), 32'd0);
`endif
  endtask

  // Entered shortly after a rising edge; drives one cycle of inputs and advances the model.
  task automatic cycle(input logic v, input logic c, input logic r, input logic [31:2] t,
                       input logic cm, input logic rd, input int rid,
                       input logic rc, input logic rr, input logic [31:2] rt);
    logic exp_ready, acc;
    int k;
    chk("pred_target", 32'(pred_target_o), 32'(m_stack[m_sp]));
    chk("pred_valid", 32'(pred_valid_o), 32'(m_cnt != 0));
    f_valid_i = v; f_call_i = c; f_ret_i = r; f_target_i = t; commit_i = cm;
    redirect_i = rd; redirect_id_i = 2'(rid); redirect_call_i = rc;
    redirect_ret_i = rr; redirect_target_i = rt;
    #1;
    exp_ready = (m_stall == 0) && (m_tail - m_head < 4) && !rd;
    chk("f_ready", 32'(f_ready_o), 32'(exp_ready));
    chk("ckpt_id", 32'(f_ckpt_id_o), 32'(m_tail % 4));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    f_valid_i = 0; commit_i = 0; redirect_i = 0;
    if (cm && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_head++;
    end
    if (rd) begin
      m_rec++;
      k = -1;
      for (int i = 0; i < m_q.size(); i++) if (k < 0 && m_q[i].id == rid) k = i;
      if (k >= 0) begin
        m_sp = m_q[k].sp;
        m_stack[m_sp] = m_q[k].top;
        m_cnt = m_q[k].cnt;
        while (m_q.size() > k + 1) void'(m_q.pop_back());
        m_tail = m_head + k + 1;
      end
      p_call = rc; p_ret = rr; p_tgt = rt;
      m_stall = 2;
    end else begin
      if (m_stall == 2) apply_op(p_call, p_ret, p_tgt);
      if (m_stall > 0) m_stall--;
      if (acc) begin
        m_q.push_back('{m_tail % 4, m_sp, m_stack[m_sp], m_cnt});
        apply_op(c, r, t);
        m_tail++;
      end
    end
    check_stats();
  endtask

  task automatic fetch(input logic c, input logic r, input logic [31:2] t, input logic cm);
    cycle(1'b1, c, r, t, cm, 1'b0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input logic cm);
    cycle(1'b0, 1'b0, 1'b0, '0, cm, 1'b0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic redir(input int rid, input logic rc, input logic rr, input logic [31:2] rt,
                       input logic cm);
    cycle(1'b0, 1'b0, 1'b0, '0, cm, 1'b1, rid, rc, rr, rt);
  endtask

  task automatic do_reset();
    rst_n = 0; f_valid_i = 0; f_call_i = 0; f_ret_i = 0; f_target_i = '0; commit_i = 0;
    redirect_i = 0; redirect_id_i = '0; redirect_call_i = 0; redirect_ret_i = 0;
    redirect_target_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(f_ready_o), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    chk("rst_pred_target", 32'(pred_target_o), 32'd0);
    chk("rst_ckpt_id", 32'(f_ckpt_id_o), 32'd0);
    model_reset();
    check_stats();
    rst_n = 1;
  endtask

  initial begin
    logic rd, cm, v, c, r, rc, rr;
    int k, sz;

    // Two calls then a return.
    do_reset();
    chk("t1_id0", 32'(f_ckpt_id_o), 32'd0);
    fetch(1, 0, 30'h100, 0);
    chk("t1_id1", 32'(f_ckpt_id_o), 32'd1);
    fetch(1, 0, 30'h200, 0);
    chk("t1_top200", 32'(pred_target_o), 32'h200);
    chk("t1_valid", 32'(pred_valid_o), 32'd1);
    fetch(0, 1, '0, 0);
    chk("t1_top100", 32'(pred_target_o), 32'h100);

    // Overflow by one, then drain.
    do_reset();
    for (int i = 1; i <= 9; i++) fetch(1, 0, 30'(i), 1);
    chk("t2_top9", 32'(pred_target_o), 32'h9);
    for (int i = 0; i < 7; i++) fetch(0, 1, '0, 1);
    chk("t2_top2", 32'(pred_target_o), 32'h2);
    fetch(0, 1, '0, 1);
    chk("t2_empty", 32'(pred_valid_o), 32'd0);
`ifdef RAS_CTRL_STATS_EN
    chk("t2_ovf", 32'(overflow_cnt_o), 32'd1);
`endif

    // Redirect to a middle checkpoint with a corrected return.
    do_reset();
    fetch(1, 0, 30'hA, 0);
    fetch(1, 0, 30'hB, 0);
    fetch(0, 1, '0, 0);
    redir(1, 0, 1, '0, 0);
    chk("t3_restored_top", 32'(pred_target_o), 32'hA);
    chk("t3_restored_valid", 32'(pred_valid_o), 32'd1);
    idle(0);
    idle(0);
    chk("t3_valid_after", 32'(pred_valid_o), 32'd0);
    chk("t3_tail", 32'(f_ckpt_id_o), 32'd2);
    chk("t3_ready_back", 32'(f_ready_o), 32'd1);

    // Fill the checkpoint queue and wrap the ID.
    do_reset();
    for (int i = 0; i < 4; i++) fetch(0, 0, '0, 0);
    chk("t4_full", 32'(f_ready_o), 32'd0);
    idle(1);
    chk("t4_ready", 32'(f_ready_o), 32'd1);
    chk("t4_wrap_id", 32'(f_ckpt_id_o), 32'd0);
    fetch(1, 0, 30'h77, 0);

    // A second redirect during RESTORE wins.
    do_reset();
    fetch(1, 0, 30'h10, 0);
    fetch(1, 0, 30'h20, 0);
    fetch(1, 0, 30'h30, 0);
    redir(2, 1, 0, 30'h99, 0);
    redir(0, 1, 0, 30'h55, 0);
    idle(0);
    idle(0);
    chk("t5_top", 32'(pred_target_o), 32'h55);
    chk("t5_valid", 32'(pred_valid_o), 32'd1);
    chk("t5_tail", 32'(f_ckpt_id_o), 32'd1);

    // Tail call, then repair it with commit in the same cycle.
    do_reset();
    fetch(1, 0, 30'h300, 0);
    fetch(1, 1, 30'h400, 0);
    chk("t6_top400", 32'(pred_target_o), 32'h400);
    redir(1, 0, 0, '0, 1);
    idle(0);
    idle(0);
    chk("t6_top300", 32'(pred_target_o), 32'h300);
    chk("t6_valid", 32'(pred_valid_o), 32'd1);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      sz = m_q.size();
      rd = (sz > 0) && ($urandom_range(0, 9) == 0);
      cm = ($urandom_range(0, 9) < 3);
      if (rd) begin
        if (sz < 2) cm = 0;
        k = cm ? $urandom_range(1, sz - 1) : $urandom_range(0, sz - 1);
        rc = 1'($urandom()); rr = 1'($urandom());
        redir(m_q[k].id, rc, rr, 30'($urandom()), cm);
      end else begin
        v = ($urandom_range(0, 9) < 7); c = 1'($urandom()); r = 1'($urandom());
        cycle(v, c, r, 30'($urandom()), cm, 1'b0, 0, 1'b0, 1'b0, '0);
      end
    end
    idle(0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Speculation controller for the return address stack (RAS) in the BPU.
- Sequences call/return push/pop requests from the fetch stage and owns the stack storage and pointer.
- Takes a checkpoint per accepted request so the backend can repair the stack after a misprediction.
- Sits between the fetch-stage predictor (request side) and the backend commit/redirect path (repair side).

Parameters:
STACK_DEPTH, 8, number of stack entries; power of two, >=2; SP_W = $clog2(STACK_DEPTH)
CKPT_DEPTH, 4, number of in-flight checkpoints; power of two, >=2; ID_W = $clog2(CKPT_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
f_valid_i  in  1  fetch request valid
f_ready_o  out  1  controller can accept a fetch request
f_call_i  in  1  request is a call (push)
f_ret_i  in  1  request is a return (pop)
f_target_i  in  [31:2]  return address to push on call
f_ckpt_id_o  out  ID_W  checkpoint ID allocated to the accepted request; valid in the accept cycle
pred_target_o  out  [31:2]  current top of stack, combinational
pred_valid_o  out  1  stack non-empty (count != 0)
commit_i  in  1  free the oldest checkpoint
redirect_i  in  1  misprediction repair request
redirect_id_i  in  ID_W  checkpoint to restore
redirect_call_i  in  1  corrected op is a call
redirect_ret_i  in  1  corrected op is a return
redirect_target_i  in  [31:2]  corrected push address

Behaviour:
- Reset state: sp=0, count=0, all stack entries=0, checkpoint queue head=tail=0 (empty), state=NORMAL.
- Reset-time outputs: f_ready_o=0 while rst_n=0, pred_valid_o=0, pred_target_o=0, f_ckpt_id_o=0.
- Stack is circular. sp indexes the top entry and wraps modulo STACK_DEPTH. count saturates at STACK_DEPTH on push and at 0 on pop.
  - Push when full overwrites the oldest entry.
  - Pop when empty: sp still decrements, count stays 0.
- f_ready_o = (state==NORMAL) & !ckpt_full & !redirect_i.
- Accept = f_valid_i & f_ready_o. On accept, in the same clock edge:
  - Write checkpoint {sp, stack[sp], count} at tail; tail++. f_ckpt_id_o = tail before the increment.
  - Call only: sp<=sp+1, stack[sp+1]<=f_target_i, count+1 (saturating).
  - Return only: sp<=sp-1, count-1 (saturating).
  - Call and return together (tail call): stack[sp]<=f_target_i; sp and count unchanged.
  - Neither: checkpoint is still allocated; stack is untouched.
- commit_i: head++ if the queue is non-empty; ignored if empty. It is processed in any state and in the same cycle as an accept.
- FSM states: NORMAL, RESTORE, REPLAY.
  - NORMAL --redirect_i--> RESTORE.
    - Latch the redirect op and target.
    - Same edge: sp<=ckpt.sp, stack[ckpt.sp]<=ckpt.top, count<=ckpt.count, tail<=redirect_id_i+1. This discards all younger checkpoints.
    - The restored checkpoint stays allocated.
  - RESTORE -> REPLAY unconditionally. Apply the latched corrected op using the accept rules, without allocating a checkpoint.
  - REPLAY -> NORMAL unconditionally.
  - redirect_i in RESTORE or REPLAY restarts the restore from the new redirect_id_i. The newest redirect wins.
  - f_ready_o=0 in the redirect cycle, RESTORE and REPLAY. Minimum 3-cycle fetch stall per redirect.
- Commit and redirect in the same cycle: head advances first, then tail is set. A redirect_id_i outside [head, tail) is a protocol error; behaviour is undefined and an assertion fires in simulation.
- Full and empty checkpoint queue are distinguished with an extra wrap bit on head and tail.
- pred_target_o and pred_valid_o reflect registered state only. No bypass of the current-cycle push.

Optional Feature:
RAS_CTRL_STATS_EN
- Defined: adds two 16-bit saturating counters, both cleared by reset, on output ports overflow_cnt_o [15:0] and recover_cnt_o [15:0].
  - overflow_cnt_o counts pushes made while count==STACK_DEPTH.
  - recover_cnt_o counts redirect_i cycles.
- Not defined: both ports still exist and are tied to 0; no counter flops are built.

Test Plan:
1. After reset, accept call with 0x100, then call with 0x200 -> pred_target_o=0x200, pred_valid_o=1, f_ckpt_id_o=0 then 1. Then accept return -> pred_target_o=0x100.
2. STACK_DEPTH=8: 9 calls with 0x1..0x9, committing each the next cycle -> count stays 8, the entry holding 0x1 is overwritten. 8 returns expose 0x9..0x2, then pred_valid_o=0. STATS_EN: overflow_cnt_o=1.
3. Call 0xA (id0), call 0xB (id1), return (id2), then redirect id1 with redirect_ret_i -> stack restored to {0xA}, tail=2. After REPLAY, pred_valid_o=0. f_ready_o is low for exactly 3 cycles.
4. 4 accepts with no commit -> f_ready_o=0. commit_i -> f_ready_o=1 next cycle. Next accept gets f_ckpt_id_o=0 (wrap).
5. Second redirect during RESTORE, targeting an older id -> final state matches that older checkpoint plus its replayed op.
6. Call 0x300 then tail call (call+ret) with 0x400 -> pred_target_o=0x400, count unchanged at 1. Redirect to the tail call's checkpoint with no op -> pred_target_o=0x300.
